// File: rtl/dr_scan_seq_ctrl.sv
// dr_scan_seq_ctrl: load/capture/unload sequencer for one dual-rail return-to-spacer scan chain
module dr_scan_seq_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 3
) (
    input  logic                 C,
    input  logic                 RN,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic                 SO_1,
    input  logic                 SO_0,
    output logic                 SE_1,
    output logic                 SE_0,
    output logic                 SD_1,
    output logic                 SD_0,
    output logic                 SP,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] res_out,
    output logic                 err
);
    typedef enum logic [3:0] {IDLE, LOAD_D, LOAD_S, CAP_D, CAP_S, UNL_D, UNL_S, FLUSH, DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CHAIN_LEN-1:0] pat_q;
    logic last, run, go;
    assign last = cnt == CNT_W'(CHAIN_LEN - 1);
    assign run  = state inside {LOAD_D, LOAD_S, CAP_D, CAP_S, UNL_D, UNL_S};
    assign go   = run && !abort;
    always_ff @(posedge C) begin
        if (!RN) begin
            state   <= IDLE;
            cnt     <= '0;
            pat_q   <= '0;
            res_out <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                pat_q   <= pat_in;
                res_out <= '0;
                err     <= 1'b0;
                cnt     <= '0;
            end
            if (go && (state == LOAD_S || state == UNL_S))
                cnt <= last ? '0 : cnt + 1'b1;
            if (go && state == UNL_D) begin
                res_out[cnt] <= SO_1 & ~SO_0;
                if (SO_1 == SO_0)
                    err <= 1'b1;
            end
            if (go && state == UNL_S && (SO_1 | SO_0))
                err <= 1'b1;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD_D : IDLE;
            LOAD_D:  state_nxt = LOAD_S;
            LOAD_S:  state_nxt = last ? CAP_D : LOAD_D;
            CAP_D:   state_nxt = CAP_S;
            CAP_S:   state_nxt = UNL_D;
            UNL_D:   state_nxt = UNL_S;
            UNL_S:   state_nxt = last ? DONE : UNL_D;
            default: state_nxt = IDLE;
        endcase
        if (run && abort)
            state_nxt = FLUSH;
    end
    always_comb begin
        SP   = !(state inside {LOAD_D, CAP_D, UNL_D});
        SE_1 = state == LOAD_D || state == UNL_D;
        SE_0 = state == CAP_D;
        SD_1 = state == LOAD_D && pat_q[cnt];
        SD_0 = (state == LOAD_D && !pat_q[cnt]) || state == UNL_D;
        busy = run;
        done = state == DONE;
    end
endmodule

// File: tb/tb_dr_scan_seq_ctrl.sv
// tb_dr_scan_seq_ctrl: randomized directed bench with an ideal dual-rail scan chain model
module tb_dr_scan_seq_ctrl;
    localparam int N = 8;
    logic C = 1'b0, RN = 1'b0, start = 1'b0, abort = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic SO_1, SO_0, SE_1, SE_0, SD_1, SD_0, SP, busy, done, err;
    logic [N-1:0] res_out;
    int tests = 0, fails = 0;
    logic [N-1:0] chain = '0;
    logic captured = 1'b0;
    int sh = 0;
    logic inj_en = 1'b0, cap_inv = 1'b0;
    int inj_idx = 0;

    dr_scan_seq_ctrl #(.CHAIN_LEN(N), .CNT_W(3)) dut (
        .C(C), .RN(RN), .start(start), .abort(abort), .pat_in(pat_in),
        .SO_1(SO_1), .SO_0(SO_0), .SE_1(SE_1), .SE_0(SE_0), .SD_1(SD_1), .SD_0(SD_0),
        .SP(SP), .busy(busy), .done(done), .res_out(res_out), .err(err)
    );

    always #5 C = ~C;

    always @(posedge C) begin
        if (!busy)
            captured <= 1'b0;
        else if (!SP && {SE_1, SE_0} == 2'b10) begin
            chain <= {chain[N-2:0], SD_1};
            if (captured)
                sh <= sh + 1;
        end else if (!SP && {SE_1, SE_0} == 2'b01) begin
            chain    <= cap_inv ? ~chain : chain;
            captured <= 1'b1;
            sh       <= 0;
        end
    end

    always_comb begin
        {SO_1, SO_0} = 2'b00;
        if (!SP)
            {SO_1, SO_0} = (inj_en && captured && sh == inj_idx) ? 2'b11 : (chain[N-1] ? 2'b10 : 2'b01);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_sp"}, 32'(SP), 32'd1);
        chk({tag, "_se_sd"}, {28'd0, SE_1, SE_0, SD_1, SD_0}, 32'd0);
        chk({tag, "_busy_done_err"}, {29'd0, busy, done, err}, 32'd0);
        chk({tag, "_res"}, 32'(res_out), 32'd0);
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic run(input logic [N-1:0] pat, input bit inv, input bit inj, input int idx,
                       input int abort_k, input int rst_k);
        logic [N-1:0] exp_res;
        logic [1:0] e_se, e_sd;
        logic e_sp;
        int last_k, dpulses;
        last_k  = 4 * N + 3;
        cap_inv = inv;
        inj_en  = inj;
        inj_idx = idx;
        exp_res = inv ? ~pat : pat;
        if (inj) exp_res[idx] = 1'b0;
        pat_in = pat;
        start  = 1'b1;
        tick();
        for (int k = 1; k <= last_k; k++) begin
            e_sp = 1'b1; e_se = 2'b00; e_sd = 2'b00;
            if (k <= 2 * N && k % 2 == 1) begin
                e_sp = 1'b0; e_se = 2'b10; e_sd = pat[(k - 1) / 2] ? 2'b10 : 2'b01;
            end else if (k == 2 * N + 1) begin
                e_sp = 1'b0; e_se = 2'b01;
            end else if (k >= 2 * N + 3 && k <= 4 * N + 2 && (k - 2 * N - 3) % 2 == 0) begin
                e_sp = 1'b0; e_se = 2'b10; e_sd = 2'b01;
            end
            chk($sformatf("sp_k%0d", k), 32'(SP), 32'(e_sp));
            chk($sformatf("se_k%0d", k), 32'({SE_1, SE_0}), 32'(e_se));
            chk($sformatf("sd_k%0d", k), 32'({SD_1, SD_0}), 32'(e_sd));
            chk($sformatf("busy_done_k%0d", k), 32'({busy, done}), (k <= 4 * N + 2) ? 32'd2 : 32'd1);
            if (k == last_k) begin
                chk("res_out", 32'(res_out), 32'(exp_res));
                chk("err", 32'(err), 32'(inj));
            end
            start = 1'($urandom_range(0, 1));
            if (k == abort_k) begin
                abort = 1'b1;
                start = 1'b0;
                tick();
                abort = 1'b0;
                chk("flush_sp", 32'(SP), 32'd1);
                chk("flush_se_sd", {28'd0, SE_1, SE_0, SD_1, SD_0}, 32'd0);
                chk("flush_done", 32'(done), 32'd0);
                tick();
                chk("abort_idle", 32'({busy, done}), 32'd0);
                chk("abort_hold", {23'd0, res_out, err}, 32'd0);
                dpulses = 0;
                for (int j = 0; j < 40; j++) begin
                    tick();
                    dpulses += int'(done) + int'(busy);
                end
                chk("abort_no_done", 32'(dpulses), 32'd0);
                return;
            end
            if (k == rst_k) begin
                RN    = 1'b0;
                start = 1'b0;
                tick();
                RN = 1'b1;
                chk_rst("midrst");
                return;
            end
            tick();
        end
        start = 1'b0;
        chk("post_done_idle", 32'({busy, done}), 32'd0);
        chk("post_done_hold", 32'(res_out), 32'(exp_res));
    endtask

    initial begin
        start  = 1'b1;
        pat_in = 8'h3C;
        tick();
        tick();
        chk_rst("reset");
        start = 1'b0;
        RN    = 1'b1;
        tick();
        chk_rst("idle");
        run(8'hA5, 1'b0, 1'b0, 0, -1, -1);
        run(8'hA5, 1'b1, 1'b0, 0, -1, -1);
        run(8'hFF, 1'b0, 1'b1, 3, -1, -1);
        run(8'h96, 1'b0, 1'b0, 0, -1, -1);
        run(8'hC3, 1'b0, 1'b0, 0, 5, -1);
        run(8'h5A, 1'b0, 1'b0, 0, -1, 2 * N + 4 + 2 * 4);
        run(8'hFF, 1'b0, 1'b0, 0, -1, -1);
        for (int i = 0; i < 6; i++)
            run(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, N - 1)), -1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
